// File: rtl/mem_load_pkg.sv
// Shared types and constants for the load-mode memory sequencer.
package mem_load_pkg;

  localparam int unsigned TGT_W = 8;
  localparam logic [TGT_W-1:0] TGT_INSTR = 8'h00;
  localparam logic [TGT_W-1:0] TGT_DATA  = 8'h01;

  // Frame states are named after the byte most recently consumed.
  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_IDLE,
    S_TGT,
    S_LEN0,
    S_LEN1,
    S_PAY,
    S_CHK
  } state_t;

  function automatic logic is_busy(input state_t s);
    return s inside {S_TGT, S_LEN0, S_LEN1, S_PAY, S_CHK};
  endfunction

endpackage

// File: rtl/mem_load_ctrl_sync2.sv
// Two-flop synchroniser for a slow asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/mem_load_ctrl.sv
// Load-mode sequencer: parses framed UART bytes into 32-bit memory writes
// and holds the CPU in reset while loading.
module mem_load_ctrl
  import mem_load_pkg::*;
#(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned TIMEOUT  = 1_000_000,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_switch,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_en,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

  logic w_mode;

  sync2 u_sync_mode (
    .clk (clk),
    .rst (rst),
    .d   (mode_switch),
    .q   (w_mode)
  );

  state_t              r_state,    w_state_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
  logic [IDLE_W-1:0]   r_idle_cnt, w_idle_nxt;
  logic [1:0]          r_bcnt,     w_bcnt_nxt;
  logic [23:0]         r_shift,    w_shift_nxt;
  logic [ADDR_W:0]     r_wcnt,     w_wcnt_nxt;
  logic [ADDR_W:0]     r_addr,     w_addr_nxt;
  logic [7:0]          r_len_lo,   w_len_lo_nxt;
  logic [7:0]          r_xor,      w_xor_nxt;
  logic                r_sel,      w_sel_nxt;
  logic                r_mem_we,   w_we_nxt;
  logic                r_mem_sel,  w_msel_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_maddr_nxt;
  logic [31:0]         r_mem_wdata, w_wdata_nxt;
  logic                r_cpu_en,   r_cpu_rst, r_busy;
  logic                r_done,     w_done_nxt;
  logic                r_err,      w_err_nxt;

  logic [15:0]         w_len;
  logic                w_len_ok;
  logic                w_timeout;

  assign w_len     = {rx_byte, r_len_lo};
  assign w_len_ok  = (w_len != 16'd0) && (32'(w_len) <= (32'd1 << ADDR_W));
  // Fires on the edge where the idle count would reach TIMEOUT.
  assign w_timeout = !rx_valid && (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold_cnt;
    w_idle_nxt   = '0;
    w_bcnt_nxt   = r_bcnt;
    w_shift_nxt  = r_shift;
    w_wcnt_nxt   = r_wcnt;
    w_addr_nxt   = r_addr;
    w_len_lo_nxt = r_len_lo;
    w_xor_nxt    = r_xor;
    w_sel_nxt    = r_sel;
    w_we_nxt     = 1'b0;
    w_msel_nxt   = r_mem_sel;
    w_maddr_nxt  = r_mem_addr;
    w_wdata_nxt  = r_mem_wdata;
    w_done_nxt   = r_done;
    w_err_nxt    = r_err;

    if (is_busy(r_state) && !rx_valid) begin
      w_idle_nxt = r_idle_cnt + 1'b1;
    end

    case (r_state)
      S_HOLD: begin
        if (r_hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
          w_hold_nxt  = '0;
          w_state_nxt = w_mode ? S_IDLE : S_RUN;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (w_mode) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (!w_mode) begin
          w_state_nxt = S_HOLD;
        end else if (rx_valid) begin
          if (rx_byte == TGT_INSTR || rx_byte == TGT_DATA) begin
            w_state_nxt = S_TGT;
            w_sel_nxt   = rx_byte[0];
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
            w_xor_nxt   = '0;
            w_bcnt_nxt  = '0;
            w_addr_nxt  = '0;
          end else begin
            w_done_nxt = 1'b0;
            w_err_nxt  = 1'b1;
          end
        end
      end
      default: begin
        if (!w_mode) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (rx_valid) begin
          case (r_state)
            S_TGT: begin
              w_len_lo_nxt = rx_byte;
              w_state_nxt  = S_LEN0;
            end
            S_LEN0: begin
              if (w_len_ok) begin
                w_wcnt_nxt  = (ADDR_W + 1)'(w_len);
                w_state_nxt = S_LEN1;
              end else begin
                w_err_nxt   = 1'b1;
                w_state_nxt = S_IDLE;
              end
            end
            S_LEN1, S_PAY: begin
              w_state_nxt = S_PAY;
              w_xor_nxt   = r_xor ^ rx_byte;
              w_bcnt_nxt  = r_bcnt + 1'b1;
              if (r_bcnt == 2'd3) begin
                w_we_nxt    = !r_addr[ADDR_W];
                w_msel_nxt  = r_sel;
                w_maddr_nxt = r_addr[ADDR_W-1:0];
                w_wdata_nxt = {rx_byte, r_shift};
                w_addr_nxt  = r_addr + 1'b1;
                w_wcnt_nxt  = r_wcnt - 1'b1;
                if (r_wcnt == (ADDR_W + 1)'(1)) w_state_nxt = S_CHK;
              end else begin
                w_shift_nxt = {rx_byte, r_shift[23:8]};
              end
            end
            S_CHK: begin
              if (rx_byte == r_xor) w_done_nxt = 1'b1;
              else                  w_err_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end
            default: ;
          endcase
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_bcnt      <= '0;
      r_shift     <= '0;
      r_wcnt      <= '0;
      r_addr      <= '0;
      r_len_lo    <= '0;
      r_xor       <= '0;
      r_sel       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_sel   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_en    <= 1'b0;
      r_cpu_rst   <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_hold_cnt  <= w_hold_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_shift     <= w_shift_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_addr      <= w_addr_nxt;
      r_len_lo    <= w_len_lo_nxt;
      r_xor       <= w_xor_nxt;
      r_sel       <= w_sel_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_sel   <= w_msel_nxt;
      r_mem_addr  <= w_maddr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_cpu_en    <= (w_state_nxt == S_RUN);
      r_cpu_rst   <= (w_state_nxt != S_RUN);
      r_busy      <= is_busy(w_state_nxt);
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_sel   = r_mem_sel;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_en    = r_cpu_en;
  assign cpu_rst   = r_cpu_rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Directed bench for mem_load_ctrl: expected writes go to a scoreboard queue
// that a negedge monitor drains; status flags are checked at fixed cycles.
module tb_mem_load_ctrl;

  localparam int unsigned AW = 14;

  logic          clk;
  logic          rst;
  logic          mode_switch;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          mem_we;
  logic          mem_sel;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_en;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;

  mem_load_ctrl #(
    .ADDR_W   (AW),
    .TIMEOUT  (16),
    .RST_HOLD (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_switch (mode_switch),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .mem_we      (mem_we),
    .mem_sel     (mem_sel),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_en      (cpu_en),
    .cpu_rst     (cpu_rst),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        sb[$];
  logic [7:0] fr[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic sel, input logic [AW-1:0] addr, input logic [31:0] data);
    wr_t w;
    w.sel  = sel;
    w.addr = addr;
    w.data = data;
    sb.push_back(w);
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      wr_t w;
      n_writes++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got sel=%0d addr=%h data=%h expected none",
                 mem_sel, mem_addr, mem_wdata);
      end else begin
        w = sb.pop_front();
        check("wr_sel",  {31'd0, mem_sel}, {31'd0, w.sel});
        check("wr_addr", {18'd0, mem_addr}, {18'd0, w.addr});
        check("wr_data", mem_wdata, w.data);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Sends fr[]; the last byte has no trailing gap so flags can be checked at once.
  task automatic send_frame(input int gap);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i], (i == fr.size() - 1) ? 0 : gap);
    end
  endtask

  initial begin
    rst         = 1'b0;
    mode_switch = 1'b0;
    rx_valid    = 1'b0;
    rx_byte     = 8'h00;
    repeat (2) tick();

    check("rst_mem_we",  {31'd0, mem_we},  32'd0);
    check("rst_mem_sel", {31'd0, mem_sel}, 32'd0);
    check("rst_addr",    {18'd0, mem_addr}, 32'd0);
    check("rst_wdata",   mem_wdata, 32'd0);
    check("rst_cpu_en",  {31'd0, cpu_en},  32'd0);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_flags",   {29'd0, busy, done, err}, 32'd0);

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_cpu_rst", {30'd0, cpu_rst, cpu_en}, 32'd2);
    end
    tick();
    check("run_after_hold", {30'd0, cpu_rst, cpu_en}, 32'd1);

    // Enter load mode: two synchroniser cycles plus one state cycle.
    mode_switch = 1'b1;
    repeat (2) tick();
    check("load_latency_still_run", {31'd0, cpu_en}, 32'd1);
    tick();
    check("load_mode_cpu_held", {30'd0, cpu_rst, cpu_en}, 32'd2);
    repeat (2) tick();

    // Frame 1: two instruction words, good checksum.
    expect_wr(1'b0, 14'd0, 32'hEFBEADDE);
    expect_wr(1'b0, 14'd1, 32'h04030201);
    fr = '{8'h00, 8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
           8'h01, 8'h02, 8'h03, 8'h04, 8'h26};
    send_frame(2);
    check("f1_done_err_busy", {29'd0, busy, done, err}, 32'b010);
    repeat (3) tick();

    // Frame 2: data memory, bad checksum.
    expect_wr(1'b1, 14'd0, 32'h44332211);
    fr = '{8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_frame(1);
    check("f2_bad_chk", {29'd0, busy, done, err}, 32'b001);
    repeat (3) tick();

    // Frame 3: three words, fully back-to-back.
    expect_wr(1'b0, 14'd0, 32'h04030201);
    expect_wr(1'b0, 14'd1, 32'h08070605);
    expect_wr(1'b0, 14'd2, 32'h0C0B0A09);
    fr = '{8'h00, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
           8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0C};
    send_frame(0);
    check("f3_b2b_done", {29'd0, busy, done, err}, 32'b010);
    repeat (3) tick();
    check("f3_write_count", n_writes, 32'd6);

    // Bad TGT, then the following bytes form a fresh valid frame.
    send_byte(8'h02, 0);
    check("bad_tgt_err", {29'd0, busy, done, err}, 32'b001);
    expect_wr(1'b0, 14'd0, 32'hD4C3B2A1);
    fr = '{8'h00, 8'h01, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h04};
    send_frame(0);
    check("after_bad_tgt_done", {29'd0, busy, done, err}, 32'b010);

    // N = 0.
    send_byte(8'h00, 0);
    check("tgt_entry_clears", {29'd0, busy, done, err}, 32'b100);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("len_zero_err", {29'd0, busy, done, err}, 32'b001);

    // N = 2^ADDR_W + 1.
    send_byte(8'h01, 1);
    send_byte(8'h01, 1);
    send_byte(8'h40, 0);
    check("len_over_err", {29'd0, busy, done, err}, 32'b001);
    repeat (2) tick();

    // Timeout mid-payload: err exactly 16 cycles after the last byte.
    expect_wr(1'b0, 14'd0, 32'h88776655);
    fr = '{8'h00, 8'h02, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    send_frame(1);
    repeat (15) tick();
    check("timeout_not_yet", {29'd0, busy, done, err}, 32'b100);
    tick();
    check("timeout_err", {29'd0, busy, done, err}, 32'b001);
    expect_wr(1'b1, 14'd0, 32'h04030201);
    fr = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_frame(1);
    check("after_timeout_done", {29'd0, busy, done, err}, 32'b010);
    repeat (2) tick();

    // Drop mode_switch mid-payload: abort to HOLD, then RUN.
    fr = '{8'h00, 8'h01, 8'h00, 8'hAA};
    send_frame(0);
    mode_switch = 1'b0;
    repeat (3) tick();
    check("abort_err", {28'd0, busy, err, cpu_rst, cpu_en}, 32'b0110);
    repeat (3) tick();
    check("abort_hold", {30'd0, cpu_rst, cpu_en}, 32'd2);
    tick();
    check("abort_run", {29'd0, err, cpu_rst, cpu_en}, 32'b101);

    repeat (4) tick();
    check("sb_empty", sb.size(), 32'd0);
    check("total_writes", n_writes, 32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
